fb_scan_arbiter: RTL and testbench

//  Shares one single-port frame-buffer memory between two users: the display scan-out and a draw/CPU writer.
//  The display scan-out is driven by the VGA sync generator's de/frame_start.

---
 rtl/fb_arb_pkg.sv | 18 +
 rtl/fb_prefetch_fifo.sv | 54 +++++
 rtl/fb_scan_arbiter.sv | 140 ++++++++++++++
 tb/tb_fb_scan_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Shared types and sizing helpers for the frame-buffer scan arbiter.
// No logic and no latency; sizing only.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] UNDER_COLOR_DEF = 16'hF81F;

  // Bits needed to hold the value n itself (not n-1), minimum 1.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fb_prefetch_fifo.sv
// Show-ahead prefetch FIFO: dout is the head word whenever empty is low.
// Latency 1 cycle push-to-visible; push while full is dropped (the caller's credit check prevents it); flush wins over push/pop.
module fb_prefetch_fifo
  import fb_arb_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DW-1:0] store [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush && (count != CW'(DEPTH));
  assign do_pop  = pop && !flush && !empty;
  assign dout    = store[rptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Single-port frame-buffer arbiter: display prefetch has priority, writer gets leftover slots; FB_WR_GUARD_EN bounds writer starvation.
// Latency: mem_* same cycle as grant, pix_data 1 cycle after de; backpressure: wr_ready low while the display holds the slot.
module fb_scan_arbiter
  import fb_arb_pkg::*;
#(
  parameter int            DW          = 16,
  parameter int            AW          = 19,
  parameter int            FB_PIXELS   = 307200,
  parameter int            FB_BASE     = 0,
  parameter int            FIFO_DEPTH  = 16,
  parameter int            MEM_LAT     = 2,
  parameter logic [DW-1:0] UNDER_COLOR = DW'(UNDER_COLOR_DEF),
  parameter int            WR_MAX_WAIT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          de,
  output logic [DW-1:0] pix_data,
  output logic          underrun,
  input  logic          underrun_clr,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

`ifdef FB_WR_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  localparam int CW  = cnt_w(FIFO_DEPTH);
  localparam int CRW = CW + 1;
  localparam int FCW = cnt_w(FB_PIXELS);
  localparam int WW  = cnt_w(WR_MAX_WAIT);

  state_t               state;
  logic [AW-1:0]        fetch_ptr;
  logic [FCW-1:0]       fetch_cnt;
  logic [MEM_LAT-1:0]   inflight;
  logic [WW-1:0]        wr_wait;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic [DW-1:0]        fifo_dout;
  logic [CRW-1:0]       credit_used;
  logic                 guard_fire;
  logic                 rd_grant;
  logic                 wr_grant;
  logic                 ret_vld;
  logic                 pop_ok;

  // Words already buffered plus words still on their way back from memory.
  assign credit_used = CRW'(fifo_count) + CRW'($countones(inflight));
  assign guard_fire  = GUARD_EN && wr_valid && (wr_wait == WW'(WR_MAX_WAIT));
  assign rd_grant    = rst_n && (state == FILL) && !frame_start && !guard_fire &&
                       (credit_used < CRW'(FIFO_DEPTH));
  assign wr_grant    = rst_n && wr_valid && !rd_grant;

  assign wr_ready  = wr_grant;
  assign mem_req   = rd_grant || wr_grant;
  assign mem_we    = wr_grant;
  assign mem_addr  = rd_grant ? fetch_ptr : (wr_grant ? wr_addr : '0);
  assign mem_wdata = wr_grant ? wr_data : '0;

  assign ret_vld = inflight[MEM_LAT-1];
  assign pop_ok  = de && !frame_start && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_ptr <= '0;
      fetch_cnt <= '0;
    end else if (frame_start) begin
      state     <= FILL;
      fetch_ptr <= AW'(FB_BASE);
      fetch_cnt <= '0;
    end else if (rd_grant) begin
      fetch_ptr <= fetch_ptr + 1'b1;
      fetch_cnt <= fetch_cnt + 1'b1;
      if (fetch_cnt == FCW'(FB_PIXELS - 1)) state <= DONE;
    end
  end

  // Returns launched before a frame_start are dropped by clearing their tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (frame_start) begin
      inflight <= '0;
    end else begin
      inflight <= (inflight << 1) | MEM_LAT'(rd_grant);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_wait <= '0;
    end else if (wr_grant) begin
      wr_wait <= '0;
    end else if (wr_valid && (wr_wait != WW'(WR_MAX_WAIT))) begin
      wr_wait <= wr_wait + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data <= '0;
      underrun <= 1'b0;
    end else begin
      if (pop_ok)  pix_data <= fifo_dout;
      else if (de) pix_data <= UNDER_COLOR;
      else         pix_data <= '0;
      if (de && !pop_ok)     underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

  fb_prefetch_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ret_vld && !frame_start),
    .pop   (pop_ok),
    .flush (frame_start),
    .din   (mem_rdata),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench: instance a (MEM_LAT=2, base 0) and instance b (MEM_LAT=4, base 100, short frame).
module tb_fb_scan_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Instance a signals
  logic        a_frame_start = 0, a_de = 0, a_underrun_clr = 0, a_wr_valid = 0;
  logic [18:0] a_wr_addr = 0;
  logic [15:0] a_wr_data = 0;
  logic [15:0] a_pix_data, a_mem_wdata, a_mem_rdata;
  logic        a_underrun, a_wr_ready, a_mem_req, a_mem_we;
  logic [18:0] a_mem_addr;

  // Instance b signals
  logic        b_frame_start = 0, b_de = 0, b_underrun_clr = 0, b_wr_valid = 0;
  logic [18:0] b_wr_addr = 0;
  logic [15:0] b_wr_data = 0;
  logic [15:0] b_pix_data, b_mem_wdata, b_mem_rdata;
  logic        b_underrun, b_wr_ready, b_mem_req, b_mem_we;
  logic [18:0] b_mem_addr;

  fb_scan_arbiter #(.FB_PIXELS(700), .FB_BASE(0), .MEM_LAT(2), .FIFO_DEPTH(16), .WR_MAX_WAIT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_start(a_frame_start), .de(a_de), .pix_data(a_pix_data),
    .underrun(a_underrun), .underrun_clr(a_underrun_clr), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));

  fb_scan_arbiter #(.FB_PIXELS(40), .FB_BASE(100), .MEM_LAT(4), .FIFO_DEPTH(16), .WR_MAX_WAIT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_start(b_frame_start), .de(b_de), .pix_data(b_pix_data),
    .underrun(b_underrun), .underrun_clr(b_underrun_clr), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

  function automatic logic [15:0] memfn(input logic [18:0] a);
    return a[15:0] ^ 16'h1234;
  endfunction

  // Fixed-latency SRAM models
  logic [18:0] a_pa [2];
  logic [18:0] b_pa [4];
  logic        b_pv [4];
  int          b_reads;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) a_pa[i] <= '0;
    end else begin
      a_pa[0] <= a_mem_addr;
      a_pa[1] <= a_pa[0];
    end
  end
  assign a_mem_rdata = memfn(a_pa[1]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        b_pa[i] <= '0;
        b_pv[i] <= 1'b0;
      end
      b_reads <= 0;
    end else begin
      b_pa[0] <= b_mem_addr;
      b_pv[0] <= b_mem_req && !b_mem_we;
      for (int i = 1; i < 4; i++) begin
        b_pa[i] <= b_pa[i-1];
        b_pv[i] <= b_pv[i-1];
      end
      if (b_frame_start) b_reads <= 0;
      else if (b_mem_req && !b_mem_we) b_reads <= b_reads + 1;
    end
  end
  assign b_mem_rdata = memfn(b_pa[3]);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_wr_valid = 1; a_wr_addr = 19'h12345; a_wr_data = 16'hABCD;
    b_wr_valid = 1; b_wr_addr = 19'h54321; b_wr_data = 16'h5555;
    repeat (3) tick();
    checks++;
    if ({a_pix_data, a_underrun, a_wr_ready, a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata} !== '0)
      $display("FAIL reset_a: got pix=%h und=%b rdy=%b req=%b we=%b addr=%h wd=%h, expected all zero",
               a_pix_data, a_underrun, a_wr_ready, a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata);
    else passes++;
    checks++;
    if ({b_pix_data, b_underrun, b_wr_ready, b_mem_req, b_mem_we, b_mem_addr, b_mem_wdata} !== '0)
      $display("FAIL reset_b: got pix=%h und=%b rdy=%b req=%b we=%b addr=%h wd=%h, expected all zero",
               b_pix_data, b_underrun, b_wr_ready, b_mem_req, b_mem_we, b_mem_addr, b_mem_wdata);
    else passes++;
    a_wr_valid = 0; b_wr_valid = 0;
    rst_n = 1;
    tick();
    checks++;
    if (a_mem_req !== 1'b0) $display("FAIL idle_no_read: mem_req=%b expected 0", a_mem_req);
    else passes++;
    // IDLE: writer owns every slot
    a_wr_valid = 1;
    #1;
    checks++;
    if ({a_wr_ready, a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 1'b1, 1'b1, 19'h12345, 16'hABCD})
      $display("FAIL idle_write: rdy=%b req=%b we=%b addr=%h wd=%h expected 1 1 1 12345 abcd",
               a_wr_ready, a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata);
    else passes++;
    tick();
    a_wr_valid = 0;
  endtask

  task automatic test_scanout();
    a_frame_start = 1;
    tick();
    a_frame_start = 0;
    repeat (25) tick();
    a_de = 1;
    for (int i = 0; i < 640; i++) begin
      tick();
      checks++;
      if (a_pix_data !== memfn(19'(i))) $display("FAIL scan_pix[%0d]: got %h expected %h", i, a_pix_data, memfn(19'(i)));
      else passes++;
    end
    a_de = 0;
    checks++;
    if (a_underrun !== 1'b0) $display("FAIL scan_underrun: got %b expected 0", a_underrun);
    else passes++;
    tick();
    checks++;
    if (a_pix_data !== 16'h0) $display("FAIL de_low_pix: got %h expected 0000", a_pix_data);
    else passes++;
  endtask

  task automatic test_guard();
    int first;
    first = -1;
    a_frame_start = 1;
    tick();
    a_frame_start = 0; a_de = 1; a_wr_valid = 1; a_wr_addr = 19'h50000; a_wr_data = 16'hBEEF;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (a_wr_ready && first < 0) begin
        first = k;
        checks++;
        if ({a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 19'h50000, 16'hBEEF})
          $display("FAIL guard_write: we=%b addr=%h wd=%h expected 1 50000 beef", a_mem_we, a_mem_addr, a_mem_wdata);
        else passes++;
      end
      tick();
      if (first >= 0) break;
    end
    a_wr_valid = 0; a_de = 0;
    checks++;
`ifdef FB_WR_GUARD_EN
    if (first !== 8) $display("FAIL guard_first_grant: got cycle %0d expected 8", first);
    else passes++;
`else
    if (first !== -1) $display("FAIL starve_no_grant: got grant at cycle %0d expected none", first);
    else passes++;
`endif
  endtask

  task automatic test_fill_writes();
    int nw, reads, bw, cyc;
    logic exp_rd;
    nw = 0; reads = 0; bw = 0; cyc = 0;
    a_frame_start = 1;
    tick();
    a_frame_start = 0; a_wr_valid = 1;
    a_wr_addr = 19'h40000; a_wr_data = 16'hC000;
    while (nw < 100 && cyc < 300) begin
      #1;
      exp_rd = (reads < 16);
`ifdef FB_WR_GUARD_EN
      if (bw == 8) exp_rd = 1'b0;
`endif
      checks++;
      if (a_wr_ready !== !exp_rd) $display("FAIL fill_wr_ready cyc %0d: got %b expected %b", cyc, a_wr_ready, !exp_rd);
      else passes++;
      checks++;
      if (exp_rd) begin
        if ({a_mem_req, a_mem_we, a_mem_addr} !== {1'b1, 1'b0, 19'(reads)})
          $display("FAIL fill_read cyc %0d: req=%b we=%b addr=%h expected 1 0 %h", cyc, a_mem_req, a_mem_we, a_mem_addr, 19'(reads));
        else passes++;
        reads++;
        if (bw < 8) bw++;
      end else begin
        if ({a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 1'b1, 19'(19'h40000 + nw), 16'(16'hC000 + nw)})
          $display("FAIL fill_write[%0d]: req=%b we=%b addr=%h wd=%h expected 1 1 %h %h", nw, a_mem_req, a_mem_we,
                   a_mem_addr, a_mem_wdata, 19'(19'h40000 + nw), 16'(16'hC000 + nw));
        else passes++;
        nw++;
        bw = 0;
      end
      tick();
      cyc++;
      a_wr_addr = 19'(19'h40000 + nw); a_wr_data = 16'(16'hC000 + nw);
    end
    a_wr_valid = 0;
    checks++;
    if (nw !== 100 || reads !== 16) $display("FAIL fill_totals: writes=%0d reads=%0d expected 100 16", nw, reads);
    else passes++;
  endtask

  task automatic test_underrun_first();
    b_frame_start = 1;
    tick();
    b_frame_start = 0; b_de = 1;
    tick();
    b_de = 0;
    checks++;
    if (b_pix_data !== 16'hF81F) $display("FAIL under_pix: got %h expected f81f", b_pix_data);
    else passes++;
    checks++;
    if (b_underrun !== 1'b1) $display("FAIL under_set: got %b expected 1", b_underrun);
    else passes++;
    b_underrun_clr = 1;
    tick();
    b_underrun_clr = 0;
    checks++;
    if (b_underrun !== 1'b0) $display("FAIL under_clr: got %b expected 0", b_underrun);
    else passes++;
  endtask

  task automatic test_restart_inflight();
    int nv;
    b_frame_start = 1;
    tick();
    b_frame_start = 0;
    repeat (25) tick();
    b_de = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b_pix_data !== memfn(19'(100 + i))) $display("FAIL pre_pix[%0d]: got %h expected %h", i, b_pix_data, memfn(19'(100 + i)));
      else passes++;
    end
    b_de = 0;
    tick();
    b_frame_start = 1;
    #1;
    nv = 0;
    for (int i = 0; i < 4; i++) nv += int'(b_pv[i]);
    checks++;
    if (nv !== 3) $display("FAIL inflight_at_restart: got %0d expected 3", nv);
    else passes++;
    tick();
    b_frame_start = 0;
    repeat (25) tick();
    b_de = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (b_pix_data !== memfn(19'(100 + i))) $display("FAIL restart_pix[%0d]: got %h expected %h", i, b_pix_data, memfn(19'(100 + i)));
      else passes++;
    end
    b_de = 0;
  endtask

  task automatic test_done_writer();
    b_de = 1;
    for (int i = 2; i < 40; i++) begin
      tick();
      checks++;
      if (b_pix_data !== memfn(19'(100 + i))) $display("FAIL done_pix[%0d]: got %h expected %h", i, b_pix_data, memfn(19'(100 + i)));
      else passes++;
    end
    b_de = 0;
    tick();
    checks++;
    if (b_reads !== 40) $display("FAIL frame_reads: got %0d expected 40", b_reads);
    else passes++;
    checks++;
    if (b_underrun !== 1'b0) $display("FAIL done_underrun: got %b expected 0", b_underrun);
    else passes++;
    b_wr_valid = 1;
    for (int i = 0; i < 20; i++) begin
      b_wr_addr = 19'(19'h60000 + i); b_wr_data = 16'(16'h7000 + i);
      #1;
      checks++;
      if ({b_wr_ready, b_mem_we, b_mem_addr} !== {1'b1, 1'b1, 19'(19'h60000 + i)})
        $display("FAIL done_write[%0d]: rdy=%b we=%b addr=%h expected 1 1 %h", i, b_wr_ready, b_mem_we, b_mem_addr, 19'(19'h60000 + i));
      else passes++;
      tick();
    end
    b_wr_valid = 0;
    checks++;
    if (b_reads !== 40) $display("FAIL done_no_reads: got %0d reads expected 40", b_reads);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_scanout();
    test_guard();
    test_fill_writes();
    test_underrun_first();
    test_restart_inflight();
    test_done_writer();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
